// File: rtl/tile_update_arbiter_pkg.sv
// Shared definitions for the tile map update arbiter.
//   - Tile codes used by the background map.
//   - Map geometry.
//   - FSM state type.
//   - Index-width helper used by the top and the round-robin picker.
package tile_pkg;

  localparam logic [7:0] BDR = 8'd0;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;
  localparam logic [7:0] TKN = 8'd4;
  localparam logic [7:0] CLK = 8'd5;

  localparam int MAP_ROWS = 12;
  localparam int MAP_COLS = 17;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, DONE} tua_state_t;

  // Width of an index into an n-entry vector.
  // Never 0, so a single requester still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_update_arbiter_if.sv
// Bus between the coin detectors / VGA timing and the tile map writer.
//   master : coin side / testbench. Drives touch, coin positions, vblank and restart.
//   slave  : the arbiter. Drives the tile map write port and the status outputs.
//
// Handshake:
//   touch[i] is a level.
//     - It is sampled every cycle and latched as a pending request.
//     - No ready is returned; the collected[i] flag is the acknowledge.
//   wr_en is a one-cycle strobe.
//     - The map must accept a write on every strobe; it has no backpressure.
//     - wr_row/wr_col/wr_data are valid while wr_en is high.
//     - They hold their last values otherwise.
interface tile_update_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 5,
  parameter int TILE_W  = 8
);
  import tile_pkg::*;

  logic [NUM_REQ-1:0]       touch;
  logic [NUM_REQ*ROW_W-1:0] req_row;
  logic [NUM_REQ*COL_W-1:0] req_col;
  logic                     vblank;
  logic                     restart;
  logic                     wr_en;
  logic [ROW_W-1:0]         wr_row;
  logic [COL_W-1:0]         wr_col;
  logic [TILE_W-1:0]        wr_data;
  logic [NUM_REQ-1:0]       collected;
  logic                     busy;
  logic [7:0]               coin_count;
  tua_state_t               state;

  modport master (
    output touch, req_row, req_col, vblank, restart,
    input  wr_en, wr_row, wr_col, wr_data, collected, busy, coin_count, state
  );

  modport slave (
    input  touch, req_row, req_col, vblank, restart,
    output wr_en, wr_row, wr_col, wr_data, collected, busy, coin_count, state
  );

endinterface

// File: rtl/tile_update_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req_i   : request mask.
//   ptr_i   : index searched first.
//   gnt_o   : one-hot grant.
//   idx_o   : index of the grant.
//   valid_o : high when any request is set.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    // Walk from ptr_i upward with wrap.
    // The first set request wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        idx_o    = IDX_W'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_update_arbiter.sv
// Sole writer of the background tile map.
//   - Latches coin touches as pending requests.
//   - Arbitrates them round-robin.
//   - Writes SKY over each collected coin, only starting a write during vblank.
//   - On restart, writes TKN back to every coin that had been collected.
//   - Restore writes take priority over coin writes.
//
// Ports:
//   vga_clock : clock.
//   reset     : asynchronous, active-high.
//   bus       : tile_update_arbiter_if slave modport. Carries:
//                 - touch, coin positions, vblank, restart (inputs);
//                 - map write port (wr_en/row/col/data);
//                 - collected, busy, coin_count and FSM state.
//
// Optional feature:
//   TILE_SCORE_EN defined   : coin_count is a saturating 8-bit counter of coins
//                             collected since reset or restart.
//   TILE_SCORE_EN undefined : coin_count is tied to 0.
module tile_update_arbiter
  import tile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 5,
  parameter int TILE_W  = 8,
  parameter logic [TILE_W-1:0] SKY_CODE = TILE_W'(SKY),
  parameter logic [TILE_W-1:0] TKN_CODE = TILE_W'(TKN)
) (
  input logic                  vga_clock,
  input logic                  reset,
  tile_update_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  tua_state_t          state_q;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [NUM_REQ-1:0]  collected_q, collected_d;
  logic [NUM_REQ-1:0]  restore_q, restore_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    w_q;
  logic [NUM_REQ-1:0]  w_oh_q;
  logic                is_rst_q;
  logic                cancel_q;
  logic                wr_en_q;
  logic [ROW_W-1:0]    wr_row_q;
  logic [COL_W-1:0]    wr_col_q;
  logic [TILE_W-1:0]   wr_data_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  logic                use_rst;
  logic [NUM_REQ-1:0]  rst_oh;
  logic [IDX_W-1:0]    rst_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic [NUM_REQ-1:0]  sel_oh;
  logic [ROW_W-1:0]    sel_row;
  logic [COL_W-1:0]    sel_col;
  logic                wr_done;
  logic                coin_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (pending_q),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Target selection for the GRANT state.
  always_comb begin
    use_rst = (restore_q != '0);
    // Isolate the lowest set bit of the restore mask.
    rst_oh  = restore_q & (~restore_q + NUM_REQ'(1));
    rst_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (restore_q[i]) rst_idx = IDX_W'(i);
    end
    sel_idx = use_rst ? rst_idx : arb_idx;
    sel_oh  = use_rst ? rst_oh  : arb_gnt;
    sel_row = bus.req_row[sel_idx*ROW_W +: ROW_W];
    sel_col = bus.req_col[sel_idx*COL_W +: COL_W];
  end

  // Request and flag masks.
  always_comb begin
    wr_done = (state_q == WRITE);
    // A coin write started before a restart still goes to the map.
    // It does not count as collected.
    coin_ok = wr_done && !is_rst_q && !cancel_q && !bus.restart;

    pending_d   = pending_q;
    collected_d = collected_q;
    restore_d   = restore_q;
    rr_d        = rr_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.touch[i] && !collected_q[i] && !use_rst) pending_d[i] = 1'b1;
    end

    if (wr_done) begin
      if (is_rst_q) begin
        restore_d = restore_q & ~w_oh_q;
      end else begin
        pending_d = pending_d & ~w_oh_q;
        rr_d      = (w_q == IDX_W'(NUM_REQ - 1)) ? '0 : w_q + IDX_W'(1);
      end
    end

    if (coin_ok) collected_d = collected_q | w_oh_q;

    // Restores still outstanding from an earlier restart are kept.
    // Every collected coin is added to them.
    if (bus.restart) begin
      restore_d   = restore_d | collected_q;
      collected_d = '0;
      pending_d   = '0;
    end
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      collected_q <= '0;
      restore_q   <= '0;
      rr_q        <= '0;
      w_q         <= '0;
      w_oh_q      <= '0;
      is_rst_q    <= 1'b0;
      cancel_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      collected_q <= collected_d;
      restore_q   <= restore_d;
      rr_q        <= rr_d;
      wr_en_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.vblank && (restore_q != '0 || pending_q != '0)) state_q <= GRANT;
        end
        GRANT: begin
          // Any request that existed on entry may have been wiped by a restart.
          // In that case return to IDLE without writing.
          if (use_rst || arb_valid) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            w_q       <= sel_idx;
            w_oh_q    <= sel_oh;
            is_rst_q  <= use_rst;
            cancel_q  <= bus.restart && !use_rst;
            wr_row_q  <= sel_row;
            wr_col_q  <= sel_col;
            wr_data_q <= use_rst ? TKN_CODE : SKY_CODE;
          end else begin
            state_q <= IDLE;
          end
        end
        WRITE:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TILE_SCORE_EN
  logic [7:0] count_q;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (bus.restart) begin
      count_q <= 8'd0;
    end else if (coin_ok && count_q != 8'hFF) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign bus.coin_count = count_q;
`else
  assign bus.coin_count = 8'd0;
`endif

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_row    = wr_row_q;
  assign bus.wr_col    = wr_col_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.collected = collected_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_tile_update_arbiter.sv
module tb_tile_update_arbiter;
  import tile_pkg::*;

  localparam int NR = 4;

`ifdef TILE_SCORE_EN
  localparam bit SCORE = 1'b1;
`else
  localparam bit SCORE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tile_update_arbiter_if #(.NUM_REQ(NR), .ROW_W(4), .COL_W(5), .TILE_W(8)) bus ();

  tile_update_arbiter #(.NUM_REQ(NR), .ROW_W(4), .COL_W(5), .TILE_W(8)) dut (
    .vga_clock (clk),
    .reset     (rst),
    .bus       (bus)
  );

  // Coin positions:
  //   coin0 (6,6)   coin1 (1,15)   coin2 (3,2)   coin3 (10,16)
  assign bus.req_row = {4'd10, 4'd3, 4'd1, 4'd6};
  assign bus.req_col = {5'd16, 5'd2, 5'd15, 5'd6};

  typedef struct {
    logic [3:0] touch;
    logic       vblank;
    logic [0:0] exp_wr_en;
    logic [3:0] exp_row;
    logic [4:0] exp_col;
    logic [7:0] exp_data;
    logic [3:0] exp_coll;
    logic [0:0] exp_busy;
  } vec_t;

  vec_t vec[9];

  logic [16:0] exp_q[$];
  int          exp_cyc[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.touch   = '0;
    bus.restart = 1'b0;
    bus.vblank  = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Expects the next write dly cycles from now.
  // Every cycle before it must have wr_en low.
  task automatic expect_write(input string nm, input int dly, input logic [3:0] r,
                              input logic [4:0] c, input logic [7:0] d);
    for (int k = 1; k < dly; k++) begin
      tick();
      chk({nm, "_quiet"}, bus.wr_en, 1'b0);
    end
    tick();
    chk({nm, "_wr_en"}, bus.wr_en, 1'b1);
    chk({nm, "_row"},   bus.wr_row, r);
    chk({nm, "_col"},   bus.wr_col, c);
    chk({nm, "_data"},  bus.wr_data, d);
  endtask

  initial begin
    // Single coin, then a repeated touch of the same coin.
    // Each row applies its inputs for one cycle, then checks the next cycle.
    vec[0] = '{4'b0001, 1'b1, 1'b0, 4'd0, 5'd0, 8'd0, 4'b0000, 1'b0};
    vec[1] = '{4'b0000, 1'b1, 1'b0, 4'd0, 5'd0, 8'd0, 4'b0000, 1'b1};
    vec[2] = '{4'b0000, 1'b1, 1'b1, 4'd6, 5'd6, 8'd1, 4'b0000, 1'b1};
    vec[3] = '{4'b0000, 1'b1, 1'b0, 4'd6, 5'd6, 8'd1, 4'b0001, 1'b1};
    vec[4] = '{4'b0000, 1'b1, 1'b0, 4'd6, 5'd6, 8'd1, 4'b0001, 1'b0};
    vec[5] = '{4'b0001, 1'b1, 1'b0, 4'd6, 5'd6, 8'd1, 4'b0001, 1'b0};
    vec[6] = '{4'b0000, 1'b1, 1'b0, 4'd6, 5'd6, 8'd1, 4'b0001, 1'b0};
    vec[7] = '{4'b0000, 1'b1, 1'b0, 4'd6, 5'd6, 8'd1, 4'b0001, 1'b0};
    vec[8] = '{4'b0000, 1'b1, 1'b0, 4'd6, 5'd6, 8'd1, 4'b0001, 1'b0};

    do_reset();
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_row",   bus.wr_row, 4'd0);
    chk("rst_col",   bus.wr_col, 5'd0);
    chk("rst_data",  bus.wr_data, 8'd0);
    chk("rst_coll",  bus.collected, 4'b0000);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_count", bus.coin_count, 8'd0);
    chk("rst_state", bus.state, IDLE);

    for (int i = 0; i < 9; i++) begin
      bus.touch  = vec[i].touch;
      bus.vblank = vec[i].vblank;
      tick();
      chk($sformatf("vec%0d_wr_en", i), bus.wr_en, vec[i].exp_wr_en);
      chk($sformatf("vec%0d_row", i),   bus.wr_row, vec[i].exp_row);
      chk($sformatf("vec%0d_col", i),   bus.wr_col, vec[i].exp_col);
      chk($sformatf("vec%0d_data", i),  bus.wr_data, vec[i].exp_data);
      chk($sformatf("vec%0d_coll", i),  bus.collected, vec[i].exp_coll);
      chk($sformatf("vec%0d_busy", i),  bus.busy, vec[i].exp_busy);
    end
    bus.touch = '0;
    chk("single_count", bus.coin_count, SCORE ? 8'd1 : 8'd0);

    // Blanking gate: a touch outside vblank waits for vblank to rise.
    bus.vblank = 1'b0;
    bus.touch  = 4'b0010;
    tick();
    bus.touch  = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("gate_no_write", bus.wr_en, 1'b0);
      chk("gate_idle", bus.busy, 1'b0);
    end
    bus.vblank = 1'b1;
    expect_write("gate", 2, 4'd1, 5'd15, 8'd1);
    tick();
    tick();
    chk("gate_coll", bus.collected, 4'b0011);

    // Fairness: all four coins touched together, starting from pointer 0.
    do_reset();
    exp_q.delete();
    exp_cyc.delete();
    exp_q.push_back({4'd6, 5'd6, 8'd1});    exp_cyc.push_back(3);
    exp_q.push_back({4'd1, 5'd15, 8'd1});   exp_cyc.push_back(7);
    exp_q.push_back({4'd3, 5'd2, 8'd1});    exp_cyc.push_back(11);
    exp_q.push_back({4'd10, 5'd16, 8'd1});  exp_cyc.push_back(15);
    bus.touch = 4'b1111;
    tick();
    bus.touch = 4'b0000;
    for (int cyc = 2; cyc <= 20; cyc++) begin
      tick();
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          chk("fair_extra_write", 32'd1, 32'd0);
        end else begin
          chk("fair_write", {bus.wr_row, bus.wr_col, bus.wr_data}, exp_q.pop_front());
          chk("fair_cycle", cyc, exp_cyc.pop_front());
        end
      end
    end
    chk("fair_missing", exp_q.size(), 0);
    chk("fair_coll", bus.collected, 4'b1111);
    chk("fair_count", bus.coin_count, SCORE ? 8'd4 : 8'd0);

    // Restart: collect coins 0 and 2, then restore both with TKN.
    do_reset();
    bus.touch = 4'b0101;
    tick();
    bus.touch = 4'b0000;
    expect_write("pre0", 2, 4'd6, 5'd6, 8'd1);
    expect_write("pre2", 4, 4'd3, 5'd2, 8'd1);
    tick();
    tick();
    chk("pre_coll", bus.collected, 4'b0101);
    chk("pre_count", bus.coin_count, SCORE ? 8'd2 : 8'd0);
    chk("pre_idle", bus.busy, 1'b0);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("rs_coll", bus.collected, 4'b0000);
    chk("rs_count", bus.coin_count, 8'd0);
    expect_write("rs0", 2, 4'd6, 5'd6, 8'd4);
    expect_write("rs2", 4, 4'd3, 5'd2, 8'd4);
    tick();
    tick();
    chk("rs_idle", bus.busy, 1'b0);
    chk("rs_coll_end", bus.collected, 4'b0000);

    // Asynchronous reset while a write strobe is high.
    do_reset();
    bus.touch = 4'b1000;
    tick();
    bus.touch = 4'b0000;
    tick();
    tick();
    chk("ar_wr_en_before", bus.wr_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_wr_en", bus.wr_en, 1'b0);
    chk("ar_row",   bus.wr_row, 4'd0);
    chk("ar_col",   bus.wr_col, 5'd0);
    chk("ar_data",  bus.wr_data, 8'd0);
    chk("ar_coll",  bus.collected, 4'b0000);
    chk("ar_busy",  bus.busy, 1'b0);
    chk("ar_count", bus.coin_count, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    bus.touch = 4'b0010;
    tick();
    bus.touch = 4'b0000;
    expect_write("ar_after", 2, 4'd1, 5'd15, 8'd1);
    tick();
    tick();
    chk("ar_after_coll", bus.collected, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
